mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter that lets the CPU instruction-fetch port and data port share a single-port synchronous RAM (`ram` with one port, or an external SRAM) in the Von-Neumann build. It sits between `cpu` and the memory inside `top`. It serialises requests, applies round-robin arbitration on conflict, and returns a one-cycle `ready` pulse per completed access, which the CPU uses as its stall release.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_rr_pick2.sv | 21 ++
 rtl/mem_arbiter.sv | 96 +++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-port to one-port memory arbiter.
//   arbState_t - FSM state encoding (IDLE / ACCESS)
//   owner_t    - which CPU port owns the RAM (instruction / data)
package mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arbState_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// mem_arbiter_rr_pick2: combinational two-requester round-robin picker.
//   req  - request vector, bit 0 and bit 1 are the two masters
//   last - index of the master granted most recently (loses a tie)
//   gnt  - one-hot grant (all zero when nothing is requested)
module mem_arbiter_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the CPU instruction-fetch and data ports share one
// single-port synchronous RAM. Each access takes an IDLE (grant, address
// out) cycle and an ACCESS (RAM data back, ready pulse) cycle.
//   clk, reset           - clock, asynchronous active-low reset
//   iReq/iAddr           - instruction read request
//   iRData/iReady        - fetched word and completion pulse
//   dReq/dWe/dMask/dAddr/dWData - data request
//   dRData/dReady        - read word (0 on writes) and completion pulse
//   memAddr/memWData/memWe/memMask/memRData - RAM port (1-cycle read latency)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iReq,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    output logic [DATA_WIDTH-1:0] iRData,
    output logic                  iReady,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [MASK_WIDTH-1:0] dMask,
    input  logic [ADDR_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWData,
    output logic [DATA_WIDTH-1:0] dRData,
    output logic                  dReady,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWData,
    output logic                  memWe,
    output logic [MASK_WIDTH-1:0] memMask,
    input  logic [DATA_WIDTH-1:0] memRData
);

    arbState_t  state;
    owner_t     owner;
    owner_t     lastGrant;
    logic       opRead;     // data op latched at grant; gates dRData
    logic [1:0] reqVec;
    logic [1:0] gnt;        // bit 0 = instruction, bit 1 = data

    // Requests are only arbitrated in IDLE, and are masked while reset is
    // held so the RAM sees no traffic during reset.
    assign reqVec = {dReq, iReq} & {2{reset}} & {2{state == ARB_IDLE}};

    mem_arbiter_rr_pick2 uPick (
        .req  (reqVec),
        .last (lastGrant == OWNER_D),
        .gnt  (gnt)
    );

    // RAM port is driven straight from the granted requester in the grant
    // cycle; the instruction port never writes.
    always_comb begin
        memAddr  = '0;
        memWData = '0;
        memWe    = 1'b0;
        memMask  = '0;
        if (gnt[1]) begin
            memAddr  = dAddr;
            memWData = dWData;
            memWe    = dWe;
            memMask  = dMask;
        end else if (gnt[0]) begin
            memAddr  = iAddr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            owner     <= OWNER_I;
            lastGrant <= OWNER_I;
            opRead    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|gnt) begin
                        owner     <= gnt[1] ? OWNER_D : OWNER_I;
                        lastGrant <= gnt[1] ? OWNER_D : OWNER_I;
                        opRead    <= ~dWe;
                        state     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: state <= ARB_IDLE;
                default:    state <= ARB_IDLE;
            endcase
        end
    end

    assign iReady = (state == ARB_ACCESS) && (owner == OWNER_I);
    assign dReady = (state == ARB_ACCESS) && (owner == OWNER_D);
    assign iRData = iReady ? memRData : '0;
    assign dRData = (dReady && opRead) ? memRData : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter with directed scenarios and randomised
// protocol-correct requesters, against a transaction-level model of the
// arbiter and a private copy of memory contents.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        iReq, dReq, dWe;
    logic [31:0] iAddr, dAddr, dWData;
    logic [3:0]  dMask;
    logic [31:0] iRData, dRData, memAddr, memWData, memRData;
    logic        iReady, dReady, memWe;
    logic [3:0]  memMask;

    // next-cycle stimulus, applied by step() at the falling edge
    logic        nRst, nIReq, nDReq, nDWe;
    logic [31:0] nIAddr, nDAddr, nDWData;
    logic [3:0]  nDMask;

    int total = 0;
    int bad   = 0;

    // harness RAM (what the DUT talks to) and model memory (what we expect)
    logic [31:0] ram [0:63];
    logic [31:0] mdl [0:63];

    // model: abstract "busy with one transaction" view
    logic        mBusy, mOwnD, mLastD;
    logic [31:0] mExpI, mExpD;
    logic        sawI, sawD;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(rstN),
        .iReq(iReq), .iAddr(iAddr), .iRData(iRData), .iReady(iReady),
        .dReq(dReq), .dWe(dWe), .dMask(dMask), .dAddr(dAddr),
        .dWData(dWData), .dRData(dRData), .dReady(dReady),
        .memAddr(memAddr), .memWData(memWData), .memWe(memWe),
        .memMask(memMask), .memRData(memRData)
    );

    always @(posedge clk) begin
        if (memWe)
            for (int b = 0; b < 4; b++)
                if (memMask[b]) ram[memAddr[7:2]][8*b +: 8] <= memWData[8*b +: 8];
        memRData <= ram[memAddr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic setWord(input int idx, input logic [31:0] v);
        ram[idx] = v;
        mdl[idx] = v;
    endtask

    task automatic step();
        logic [31:0] eAddr, eWD, eIRD, eDRD;
        logic        eWe, eIR, eDR, gI, gD;
        logic [3:0]  eMask;
        @(negedge clk);
        rstN = nRst; iReq = nIReq; iAddr = nIAddr; dReq = nDReq; dWe = nDWe;
        dAddr = nDAddr; dWData = nDWData; dMask = nDMask;
        #1;
        eAddr = 0; eWD = 0; eWe = 0; eMask = 0; eIR = 0; eDR = 0;
        eIRD = 0; eDRD = 0; gI = 0; gD = 0;
        if (!rstN) begin
            mBusy = 0; mLastD = 0;
        end else if (mBusy) begin
            if (mOwnD) begin eDR = 1; eDRD = mExpD; end
            else       begin eIR = 1; eIRD = mExpI; end
        end else begin
            // single requester wins; on a tie the one not served last wins
            gD = dReq && (!iReq || !mLastD);
            gI = iReq && !gD;
            if (gD) begin eAddr = dAddr; eWD = dWData; eWe = dWe; eMask = dMask; end
            if (gI) eAddr = iAddr;
        end
        chk("memAddr", memAddr, eAddr);
        chk("memWData", memWData, eWD);
        chk("memWe", {31'b0, memWe}, {31'b0, eWe});
        chk("memMask", {28'b0, memMask}, {28'b0, eMask});
        chk("iReady", {31'b0, iReady}, {31'b0, eIR});
        chk("dReady", {31'b0, dReady}, {31'b0, eDR});
        chk("iRData", iRData, eIRD);
        chk("dRData", dRData, eDRD);
        sawI = eIR; sawD = eDR;
        if (rstN) begin
            if (mBusy) mBusy = 0;
            else if (gI || gD) begin
                mBusy = 1; mOwnD = gD; mLastD = gD;
                if (gI) mExpI = mdl[iAddr[7:2]];
                if (gD) begin
                    mExpD = dWe ? 32'h0 : mdl[dAddr[7:2]];
                    if (dWe)
                        for (int b = 0; b < 4; b++)
                            if (dMask[b]) mdl[dAddr[7:2]][8*b +: 8] = dWData[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        logic [15:0] readyLog;
        logic        iAct, dAct;
        for (int k = 0; k < 64; k++) setWord(k, $urandom);
        mBusy = 0; mOwnD = 0; mLastD = 0; mExpI = 0; mExpD = 0;
        rstN = 0; iReq = 0; dReq = 0; dWe = 0; iAddr = 0; dAddr = 0; dWData = 0; dMask = 0;
        nRst = 0; nIReq = 0; nDReq = 0; nDWe = 0; nIAddr = 0; nDAddr = 0; nDWData = 0; nDMask = 0;

        // reset held, then idle with no requests
        step(); step();
        nRst = 1;
        for (int k = 0; k < 5; k++) step();

        // single fetch
        setWord(4, 32'hDEADBEEF);
        nIReq = 1; nIAddr = 32'h10;
        step();
        chk("fetchAddr", memAddr, 32'h10);
        step();
        chk("fetchData", iRData, 32'hDEADBEEF);
        nIReq = 0; step();

        // data write then read-back of the merged word
        setWord(8, 32'hAAAAAAAA);
        nDReq = 1; nDWe = 1; nDAddr = 32'h20; nDWData = 32'h12345678; nDMask = 4'b0011;
        step();
        chk("wrWe", {31'b0, memWe}, 32'd1);
        step();
        nDWe = 0; nDMask = 4'b0000;
        step(); step();
        chk("rdMerged", dRData, 32'hAAAA5678);
        nDReq = 0; step();

        // contention straight after reset: D, I, D, I
        nRst = 0; step();
        nRst = 1; nIReq = 1; nIAddr = 32'h04; nDReq = 1; nDAddr = 32'h08; nDWe = 0;
        readyLog = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            readyLog = {readyLog[13:0], dReady, iReady};
        end
        chk("contendOrder", {16'b0, readyLog}, {16'b0, 16'b00_10_00_01_00_10_00_01});
        nIReq = 0; nDReq = 0; step(); step();

        // reset during the ACCESS cycle of a fetch, then a tie goes to DATA
        nIReq = 1; nIAddr = 32'h0C; step();
        nRst = 0; step();
        chk("midRstReady", {31'b0, iReady}, 32'd0);
        nRst = 1; nDReq = 1; nDAddr = 32'h30; step();
        chk("postRstTie", memAddr, 32'h30);
        nIReq = 0; nDReq = 0; step(); step();

        // request dropped after one IDLE cycle still completes once
        nIReq = 1; nIAddr = 32'h14; step();
        nIReq = 0; step();
        chk("dropReady", {31'b0, iReady}, 32'd1);
        for (int k = 0; k < 3; k++) step();

        // randomised protocol-correct requesters
        iAct = 0; dAct = 0; sawI = 0; sawD = 0;
        for (int c = 0; c < 600; c++) begin
            if (iAct && sawI) iAct = 0;
            if (dAct && sawD) dAct = 0;
            if (!iAct && ($urandom_range(0, 2) != 0)) begin
                iAct = 1; nIAddr = {24'b0, 6'($urandom), 2'b00};
            end
            if (!dAct && ($urandom_range(0, 2) != 0)) begin
                dAct = 1; nDAddr = {24'b0, 6'($urandom), 2'b00};
                nDWe = 1'($urandom); nDMask = 4'($urandom); nDWData = $urandom;
            end
            nIReq = iAct; nDReq = dAct;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
